jtag_tap_param: RTL and testbench

Parametrised second-generation IEEE 1149.1 TAP controller. It contains the 16-state TAP FSM, a variable-length instruction register, and the bypass, IDCODE and boundary-scan data registers, plus an optional BIST data register. TDO is retimed on the falling edge of TCK, and the block adds CLAMP and HIGHZ instructions. It sits between the chip-level JTAG pins and the core I/O ring / BIST engine.

---
 rtl/tap_pkg.sv | 42 ++++
 rtl/tap_fsm.sv | 45 ++++
 rtl/jtag_tap_param.sv | 179 +++++++++++++++++
 tb/tb_jtag_tap_param.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tap_pkg.sv
// rtl/tap_pkg.sv - TAP state encoding, instruction kinds, opcodes and IR capture pattern
package tap_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'h0,
        RTI    = 4'h1,
        SEL_DR = 4'h2,
        CAP_DR = 4'h3,
        SH_DR  = 4'h4,
        EX1_DR = 4'h5,
        PA_DR  = 4'h6,
        EX2_DR = 4'h7,
        UPD_DR = 4'h8,
        SEL_IR = 4'h9,
        CAP_IR = 4'hA,
        SH_IR  = 4'hB,
        EX1_IR = 4'hC,
        PA_IR  = 4'hD,
        EX2_IR = 4'hE,
        UPD_IR = 4'hF
    } tap_state_t;

    typedef enum logic [2:0] {
        INS_EXTEST,
        INS_SAMPLE,
        INS_IDCODE,
        INS_RUNBIST,
        INS_CLAMP,
        INS_HIGHZ,
        INS_BYPASS
    } instr_t;

    localparam int unsigned OP_EXTEST  = 0;
    localparam int unsigned OP_SAMPLE  = 1;
    localparam int unsigned OP_IDCODE  = 2;
    localparam int unsigned OP_RUNBIST = 3;
    localparam int unsigned OP_CLAMP   = 4;
    localparam int unsigned OP_HIGHZ   = 5;

    localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/tap_fsm.sv
// rtl/tap_fsm.sv - 16-state IEEE 1149.1 TAP controller state machine
module tap_fsm
    import tap_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST_N,
    input  logic       TMS,
    output tap_state_t state_o
);

    tap_state_t state_q, state_d;

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) state_q <= TLR;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = TMS ? TLR    : RTI;
            RTI:     state_d = TMS ? SEL_DR : RTI;
            SEL_DR:  state_d = TMS ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = TMS ? EX1_DR : SH_DR;
            SH_DR:   state_d = TMS ? EX1_DR : SH_DR;
            EX1_DR:  state_d = TMS ? UPD_DR : PA_DR;
            PA_DR:   state_d = TMS ? EX2_DR : PA_DR;
            EX2_DR:  state_d = TMS ? UPD_DR : SH_DR;
            UPD_DR:  state_d = TMS ? SEL_DR : RTI;
            SEL_IR:  state_d = TMS ? TLR    : CAP_IR;
            CAP_IR:  state_d = TMS ? EX1_IR : SH_IR;
            SH_IR:   state_d = TMS ? EX1_IR : SH_IR;
            EX1_IR:  state_d = TMS ? UPD_IR : PA_IR;
            PA_IR:   state_d = TMS ? EX2_IR : PA_IR;
            EX2_IR:  state_d = TMS ? UPD_IR : SH_IR;
            UPD_IR:  state_d = TMS ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    always_comb begin
        state_o = state_q;
    end

endmodule

// File: rtl/jtag_tap_param.sv
// rtl/jtag_tap_param.sv - parametrised TAP with IR, bypass/IDCODE/BS registers; JTAG_TAP_RUNBIST_EN adds the BIST register
module jtag_tap_param
    import tap_pkg::*;
#(
    parameter int unsigned IR_LEN     = 4,
    parameter int unsigned BS_LEN     = 10,
    parameter int unsigned BIST_W     = 16,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic              TCK,
    input  logic              TRST_N,
    input  logic              TMS,
    input  logic              TDI,
    output logic              TDO,
    output logic              TDO_EN,
    input  logic [BS_LEN-1:0] Par_BS_in,
    output logic [BS_LEN-1:0] Par_BS_out,
    output logic              BS_HIGHZ,
    input  logic [BIST_W-1:0] To_BIST_reg,
    output logic [BIST_W-1:0] From_BIST_reg,
    output logic              BIST_FSM_RES,
    output logic              BIST_clk_en,
    output logic              BIST_Mode_Sel
);

    tap_state_t        state;
    instr_t            instr;
    logic [IR_LEN-1:0] ir_shift_q, ir_shift_d, ir_q, ir_d;
    logic              bypass_q, bypass_d;
    logic [31:0]       id_q, id_d;
    logic [BS_LEN-1:0] bs_shift_q, bs_shift_d, bs_upd_q, bs_upd_d;
    logic              tdo_q, tdo_d, tdo_en_q, tdo_en_d;
    logic              sel_id, sel_bs, sel_bist, bist_tdo;

    tap_fsm u_fsm (
        .TCK     (TCK),
        .TRST_N  (TRST_N),
        .TMS     (TMS),
        .state_o (state)
    );

    // Unlisted opcodes (and RUNBIST when the BIST register is absent) fall to BYPASS.
    always_comb begin
        instr = INS_BYPASS;
        case (ir_q)
            IR_LEN'(OP_EXTEST):  instr = INS_EXTEST;
            IR_LEN'(OP_SAMPLE):  instr = INS_SAMPLE;
            IR_LEN'(OP_IDCODE):  instr = INS_IDCODE;
`ifdef JTAG_TAP_RUNBIST_EN
            IR_LEN'(OP_RUNBIST): instr = INS_RUNBIST;
`endif
            IR_LEN'(OP_CLAMP):   instr = INS_CLAMP;
            IR_LEN'(OP_HIGHZ):   instr = INS_HIGHZ;
            default:             instr = INS_BYPASS;
        endcase
    end

    assign sel_id   = (instr == INS_IDCODE);
    assign sel_bs   = (instr == INS_EXTEST) || (instr == INS_SAMPLE);
    assign sel_bist = (instr == INS_RUNBIST);

    always_comb begin
        ir_shift_d = ir_shift_q;
        ir_d       = ir_q;
        case (state)
            TLR:     ir_d       = IR_LEN'(OP_IDCODE);
            CAP_IR:  ir_shift_d = IR_LEN'(IR_CAPTURE);
            SH_IR:   ir_shift_d = {TDI, ir_shift_q[IR_LEN-1:1]};
            UPD_IR:  ir_d       = ir_shift_q;
            default: ;
        endcase
    end

    always_comb begin
        bypass_d   = bypass_q;
        id_d       = id_q;
        bs_shift_d = bs_shift_q;
        bs_upd_d   = bs_upd_q;
        case (state)
            CAP_DR: begin
                bypass_d = 1'b0;
                if (sel_id) id_d       = IDCODE_VAL;
                if (sel_bs) bs_shift_d = Par_BS_in;
            end
            SH_DR: begin
                bypass_d = TDI;
                if (sel_id) id_d       = {TDI, id_q[31:1]};
                if (sel_bs) bs_shift_d = {TDI, bs_shift_q[BS_LEN-1:1]};
            end
            UPD_DR: if (sel_bs) bs_upd_d = bs_shift_q;
            default: ;
        endcase
    end

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_shift_q <= '0;
            ir_q       <= IR_LEN'(OP_IDCODE);
            bypass_q   <= 1'b0;
            id_q       <= '0;
            bs_shift_q <= '0;
            bs_upd_q   <= '0;
        end else begin
            ir_shift_q <= ir_shift_d;
            ir_q       <= ir_d;
            bypass_q   <= bypass_d;
            id_q       <= id_d;
            bs_shift_q <= bs_shift_d;
            bs_upd_q   <= bs_upd_d;
        end
    end

    always_comb begin
        tdo_d = bypass_q;
        if (state == SH_IR) tdo_d = ir_shift_q[0];
        else if (sel_id)    tdo_d = id_q[0];
        else if (sel_bs)    tdo_d = bs_shift_q[0];
        else if (sel_bist)  tdo_d = bist_tdo;
        tdo_en_d = (state == SH_DR) || (state == SH_IR);
    end

    // Falling-edge retiming gives the pin a half-cycle of hold against the next rising edge.
    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign TDO        = tdo_q;
    assign TDO_EN     = tdo_en_q;
    assign BS_HIGHZ   = (instr == INS_HIGHZ);
    assign Par_BS_out = ((instr == INS_EXTEST) || (instr == INS_CLAMP)) ? bs_upd_q : Par_BS_in;

`ifdef JTAG_TAP_RUNBIST_EN
    logic [BIST_W-1:0] bist_shift_q, bist_shift_d, bist_upd_q, bist_upd_d;

    always_comb begin
        bist_shift_d = bist_shift_q;
        bist_upd_d   = bist_upd_q;
        if (sel_bist) begin
            case (state)
                CAP_DR:  bist_shift_d = To_BIST_reg;
                SH_DR:   bist_shift_d = {TDI, bist_shift_q[BIST_W-1:1]};
                UPD_DR:  bist_upd_d   = bist_shift_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            bist_shift_q <= '0;
            bist_upd_q   <= '0;
        end else begin
            bist_shift_q <= bist_shift_d;
            bist_upd_q   <= bist_upd_d;
        end
    end

    assign bist_tdo      = bist_shift_q[0];
    assign From_BIST_reg = bist_upd_q;
    assign BIST_Mode_Sel = sel_bist;
    assign BIST_clk_en   = sel_bist && (state == RTI);
    assign BIST_FSM_RES  = sel_bist && (state == UPD_DR);
`else
    logic unused_bist;
    assign unused_bist   = ^To_BIST_reg;
    assign bist_tdo      = 1'b0;
    assign From_BIST_reg = '0;
    assign BIST_Mode_Sel = 1'b0;
    assign BIST_clk_en   = 1'b0;
    assign BIST_FSM_RES  = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_tap_param.sv
// tb/tb_jtag_tap_param.sv - randomized self-checking bench for jtag_tap_param against a queue-based scan model
module tb_jtag_tap_param;
    import tap_pkg::*;

    localparam int unsigned IR_LEN     = 4;
    localparam int unsigned BS_LEN     = 10;
    localparam int unsigned BIST_W     = 16;
    localparam logic [31:0] IDCODE_VAL = 32'h1000_0001;
`ifdef JTAG_TAP_RUNBIST_EN
    localparam bit BIST_EN = 1'b1;
`else
    localparam bit BIST_EN = 1'b0;
`endif

    logic              TCK = 1'b0;
    logic              TRST_N, TMS, TDI;
    logic              TDO, TDO_EN, BS_HIGHZ, BIST_FSM_RES, BIST_clk_en, BIST_Mode_Sel;
    logic [BS_LEN-1:0] par_bs_in, par_bs_out;
    logic [BIST_W-1:0] to_bist, from_bist;

    int checks = 0;
    int errors = 0;

    int unsigned       m_ir;
    logic [BS_LEN-1:0] m_bs_upd;
    logic [BIST_W-1:0] m_bist_upd;

    jtag_tap_param #(
        .IR_LEN(IR_LEN), .BS_LEN(BS_LEN), .BIST_W(BIST_W), .IDCODE_VAL(IDCODE_VAL)
    ) dut (
        .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
        .Par_BS_in(par_bs_in), .Par_BS_out(par_bs_out), .BS_HIGHZ(BS_HIGHZ),
        .To_BIST_reg(to_bist), .From_BIST_reg(from_bist), .BIST_FSM_RES(BIST_FSM_RES),
        .BIST_clk_en(BIST_clk_en), .BIST_Mode_Sel(BIST_Mode_Sel)
    );

    always #5 TCK = ~TCK;

    // Reference: a scan register is a FIFO of its captured bits; each TDI bit pushes one bit out.
    function automatic logic [63:0] model_scan(input logic [63:0] cap, input int len,
                                               input logic [63:0] din, input int n, output logic [63:0] fin);
        logic q[$];
        logic [63:0] o;
        o = '0;
        fin = '0;
        for (int i = 0; i < len; i++) q.push_back(cap[i]);
        for (int i = 0; i < n; i++) begin
            o[i] = q.pop_front();
            q.push_back(din[i]);
        end
        for (int i = 0; i < len; i++) fin[i] = q[i];
        return o;
    endfunction

    function automatic logic [63:0] model_dr_scan(input logic [63:0] din, input int n);
        logic [63:0] cap, fin, o;
        int len;
        cap = '0;
        len = 1;
        if (m_ir == 2) begin cap = 64'(IDCODE_VAL); len = 32; end
        else if (m_ir <= 1) begin cap = 64'(par_bs_in); len = BS_LEN; end
        else if (BIST_EN && m_ir == 3) begin cap = 64'(to_bist); len = BIST_W; end
        o = model_scan(cap, len, din, n, fin);
        if (m_ir <= 1) m_bs_upd = fin[BS_LEN-1:0];
        else if (BIST_EN && m_ir == 3) m_bist_upd = fin[BIST_W-1:0];
        return o;
    endfunction

    function automatic logic [BS_LEN-1:0] exp_par_out();
        return (m_ir == 0 || m_ir == 4) ? m_bs_upd : par_bs_in;
    endfunction

    function automatic logic [BIST_W-1:0] exp_from_bist();
        return BIST_EN ? m_bist_upd : '0;
    endfunction

    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
        #1;
    endtask

    task automatic shift(input logic [63:0] din, input int n, output logic [63:0] dout, output logic en_ok);
        dout = '0;
        en_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            dout[i] = TDO;
            if (TDO_EN !== 1'b1) en_ok = 1'b0;
            step(i == n - 1, din[i]);
        end
        if (TDO_EN !== 1'b0) en_ok = 1'b0;
    endtask

    task automatic ir_scan(input logic [IR_LEN-1:0] op, output logic [63:0] dout, output logic en_ok);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        shift(64'(op), IR_LEN, dout, en_ok);
        step(1, 0); step(0, 0);
        m_ir = op;
    endtask

    task automatic dr_scan(input logic [63:0] din, input int n, output logic [63:0] dout,
                           output logic en_ok, output logic res_upd, output logic res_rti);
        step(1, 0); step(0, 0); step(0, 0);
        shift(din, n, dout, en_ok);
        step(1, 0);
        res_upd = BIST_FSM_RES;
        step(0, 0);
        res_rti = BIST_FSM_RES;
    endtask

    task automatic test_reset();
        par_bs_in = BS_LEN'($urandom);
        TRST_N = 1'b0;
        step(1, 0);
        checks++; if (dut.state !== TLR) begin errors++; $display("FAIL reset_state: got %h expected %h", dut.state, TLR); end
        checks++; if (TDO !== 1'b0 || TDO_EN !== 1'b0) begin errors++; $display("FAIL reset_tdo: got %b%b expected 00", TDO, TDO_EN); end
        checks++; if (BS_HIGHZ !== 1'b0) begin errors++; $display("FAIL reset_highz: got %b expected 0", BS_HIGHZ); end
        checks++; if (par_bs_out !== par_bs_in) begin errors++; $display("FAIL reset_par_out: got %h expected %h", par_bs_out, par_bs_in); end
        checks++; if ({from_bist, BIST_FSM_RES, BIST_clk_en, BIST_Mode_Sel} !== '0) begin errors++; $display("FAIL reset_bist: got %h %b%b%b expected 0", from_bist, BIST_FSM_RES, BIST_clk_en, BIST_Mode_Sel); end
        TRST_N = 1'b1;
        m_ir = 2; m_bs_upd = '0; m_bist_upd = '0;
        step(0, 0);
    endtask

    task automatic test_idcode();
        logic [63:0] din, dout, exp;
        logic en_ok, ru, rr;
        din = {$urandom, $urandom};
        exp = model_dr_scan(din, 32);
        dr_scan(din, 32, dout, en_ok, ru, rr);
        checks++; if (dout !== exp || exp[31:0] !== IDCODE_VAL) begin errors++; $display("FAIL idcode_shift: got %h expected %h", dout, exp); end
        checks++; if (en_ok !== 1'b1) begin errors++; $display("FAIL idcode_tdo_en: got %b expected 1", en_ok); end
    endtask

    task automatic test_ir_bypass();
        logic [63:0] dout, exp;
        logic en_ok, ru, rr;
        ir_scan('1, dout, en_ok);
        checks++; if (dout !== 64'h1) begin errors++; $display("FAIL ir_capture: got %h expected 1", dout); end
        checks++; if (en_ok !== 1'b1) begin errors++; $display("FAIL ir_tdo_en: got %b expected 1", en_ok); end
        exp = model_dr_scan(64'b1101, 4);
        dr_scan(64'b1101, 4, dout, en_ok, ru, rr);
        checks++; if (dout !== exp) begin errors++; $display("FAIL bypass_1011: got %h expected %h", dout, exp); end
        for (int k = 0; k < 3; k++) begin
            logic [63:0] din;
            din = {$urandom, $urandom};
            exp = model_dr_scan(din, 12);
            dr_scan(din, 12, dout, en_ok, ru, rr);
            checks++; if (dout !== exp || en_ok !== 1'b1) begin errors++; $display("FAIL bypass_rand: got %h/%b expected %h/1", dout, en_ok, exp); end
        end
    endtask

    task automatic test_undefined_opcodes();
        logic [63:0] din, dout, exp, idout;
        logic en_ok, ru, rr;
        for (int op = 6; op < 15; op++) begin
            ir_scan(IR_LEN'(op), idout, en_ok);
            din = {$urandom, $urandom};
            exp = model_dr_scan(din, 8);
            dr_scan(din, 8, dout, en_ok, ru, rr);
            checks++; if (dout !== exp || BS_HIGHZ !== 1'b0) begin errors++; $display("FAIL undef_op_%0d: got %h hz=%b expected %h hz=0", op, dout, BS_HIGHZ, exp); end
        end
    endtask

    task automatic test_sample_extest();
        logic [63:0] dout, exp, din;
        logic en_ok, ru, rr;
        par_bs_in = 10'h2A5;
        ir_scan(IR_LEN'(1), dout, en_ok);
        checks++; if (par_bs_out !== par_bs_in) begin errors++; $display("FAIL sample_par_out: got %h expected %h", par_bs_out, par_bs_in); end
        exp = model_dr_scan(64'h155, BS_LEN);
        dr_scan(64'h155, BS_LEN, dout, en_ok, ru, rr);
        checks++; if (dout !== exp || dout !== 64'h2A5) begin errors++; $display("FAIL sample_capture: got %h expected %h", dout, exp); end
        par_bs_in = BS_LEN'($urandom);
        ir_scan(IR_LEN'(0), dout, en_ok);
        checks++; if (par_bs_out !== exp_par_out() || par_bs_out !== 10'h155) begin errors++; $display("FAIL extest_preload: got %h expected %h", par_bs_out, exp_par_out()); end
        din = 64'($urandom);
        exp = model_dr_scan(din, BS_LEN);
        dr_scan(din, BS_LEN, dout, en_ok, ru, rr);
        checks++; if (dout !== exp) begin errors++; $display("FAIL extest_capture: got %h expected %h", dout, exp); end
        checks++; if (par_bs_out !== exp_par_out()) begin errors++; $display("FAIL extest_update: got %h expected %h", par_bs_out, exp_par_out()); end
    endtask

    task automatic test_highz_clamp();
        logic [63:0] dout, exp, din;
        logic en_ok, ru, rr;
        par_bs_in = BS_LEN'($urandom);
        ir_scan(IR_LEN'(5), dout, en_ok);
        checks++; if (BS_HIGHZ !== 1'b1 || par_bs_out !== exp_par_out()) begin errors++; $display("FAIL highz: got hz=%b out=%h expected hz=1 out=%h", BS_HIGHZ, par_bs_out, exp_par_out()); end
        din = 64'($urandom);
        exp = model_dr_scan(din, 6);
        dr_scan(din, 6, dout, en_ok, ru, rr);
        checks++; if (dout !== exp) begin errors++; $display("FAIL highz_bypass: got %h expected %h", dout, exp); end
        ir_scan(IR_LEN'(4), dout, en_ok);
        checks++; if (BS_HIGHZ !== 1'b0 || par_bs_out !== exp_par_out()) begin errors++; $display("FAIL clamp: got hz=%b out=%h expected hz=0 out=%h", BS_HIGHZ, par_bs_out, exp_par_out()); end
        din = 64'($urandom);
        exp = model_dr_scan(din, 6);
        dr_scan(din, 6, dout, en_ok, ru, rr);
        checks++; if (dout !== exp || par_bs_out !== exp_par_out()) begin errors++; $display("FAIL clamp_bypass: got %h/%h expected %h/%h", dout, par_bs_out, exp, exp_par_out()); end
    endtask

    task automatic test_runbist();
        logic [63:0] dout, exp;
        logic en_ok, ru, rr;
        to_bist = 16'h1234;
        ir_scan(IR_LEN'(3), dout, en_ok);
        exp = model_dr_scan(64'hBEEF, BIST_W);
        dr_scan(64'hBEEF, BIST_W, dout, en_ok, ru, rr);
        checks++; if (dout !== exp) begin errors++; $display("FAIL runbist_shift: got %h expected %h", dout, exp); end
        checks++; if (from_bist !== exp_from_bist()) begin errors++; $display("FAIL runbist_from: got %h expected %h", from_bist, exp_from_bist()); end
`ifdef JTAG_TAP_RUNBIST_EN
        checks++; if (dout !== 64'h1234 || from_bist !== 16'hBEEF) begin errors++; $display("FAIL runbist_values: got %h/%h expected 1234/beef", dout, from_bist); end
        checks++; if (ru !== 1'b1 || rr !== 1'b0) begin errors++; $display("FAIL runbist_res_pulse: got %b%b expected 10", ru, rr); end
        checks++; if (BIST_clk_en !== 1'b1 || BIST_Mode_Sel !== 1'b1) begin errors++; $display("FAIL runbist_idle: got clk_en=%b mode=%b expected 11", BIST_clk_en, BIST_Mode_Sel); end
`else
        checks++; if ({ru, rr, BIST_clk_en, BIST_Mode_Sel} !== 4'b0000) begin errors++; $display("FAIL runbist_absent: got %b%b%b%b expected 0000", ru, rr, BIST_clk_en, BIST_Mode_Sel); end
`endif
    endtask

    task automatic test_five_tms();
        logic [63:0] dout, exp, din;
        logic en_ok, ru, rr;
        ir_scan('1, dout, en_ok);
        step(1, 0); step(0, 0); step(0, 0); step(0, 1);
        for (int k = 0; k < 5; k++) step(1, 0);
        checks++; if (dut.state !== TLR) begin errors++; $display("FAIL five_tms_state: got %h expected %h", dut.state, TLR); end
        m_ir = 2;
        step(0, 0);
        din = 64'($urandom);
        exp = model_dr_scan(din, 32);
        dr_scan(din, 32, dout, en_ok, ru, rr);
        checks++; if (dout !== exp) begin errors++; $display("FAIL five_tms_idcode: got %h expected %h", dout, exp); end
    endtask

    task automatic test_async_reset();
        logic [63:0] dout, exp, din;
        logic en_ok, ru, rr;
        ir_scan('1, dout, en_ok);
        step(1, 0); step(0, 0); step(0, 0); step(0, 1); step(0, 0);
        checks++; if (TDO_EN !== 1'b1) begin errors++; $display("FAIL async_pre_en: got %b expected 1", TDO_EN); end
        @(posedge TCK);
        #2;
        TRST_N = 1'b0;
        #1;
        checks++; if (TDO_EN !== 1'b0 || dut.state !== TLR) begin errors++; $display("FAIL async_reset: got en=%b state=%h expected en=0 state=%h", TDO_EN, dut.state, TLR); end
        @(negedge TCK);
        #1;
        TRST_N = 1'b1;
        m_ir = 2;
        step(0, 0);
        din = 64'($urandom);
        exp = model_dr_scan(din, 32);
        dr_scan(din, 32, dout, en_ok, ru, rr);
        checks++; if (dout !== exp) begin errors++; $display("FAIL async_idcode: got %h expected %h", dout, exp); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] dout, exp, din, idout;
        logic en_ok, ru, rr;
        int n;
        logic [IR_LEN-1:0] op;
        for (int k = 0; k < 20; k++) begin
            op = IR_LEN'($urandom_range(0, 15));
            par_bs_in = BS_LEN'($urandom);
            to_bist = BIST_W'($urandom);
            ir_scan(op, idout, en_ok);
            checks++; if (idout !== 64'h1 || BS_HIGHZ !== (m_ir == 5) || BIST_Mode_Sel !== (BIST_EN && m_ir == 3) || BIST_clk_en !== (BIST_EN && m_ir == 3)) begin errors++; $display("FAIL b2b_ir op=%0d: got ir=%h hz=%b mode=%b clk=%b", op, idout, BS_HIGHZ, BIST_Mode_Sel, BIST_clk_en); end
            checks++; if (par_bs_out !== exp_par_out()) begin errors++; $display("FAIL b2b_par_pre op=%0d: got %h expected %h", op, par_bs_out, exp_par_out()); end
            n = $urandom_range(1, 40);
            din = {$urandom, $urandom};
            exp = model_dr_scan(din, n);
            dr_scan(din, n, dout, en_ok, ru, rr);
            checks++; if (dout !== exp || en_ok !== 1'b1) begin errors++; $display("FAIL b2b_dr op=%0d n=%0d: got %h/%b expected %h/1", op, n, dout, en_ok, exp); end
            checks++; if (ru !== (BIST_EN && m_ir == 3) || rr !== 1'b0) begin errors++; $display("FAIL b2b_res op=%0d: got %b%b expected %b0", op, ru, rr, (BIST_EN && m_ir == 3)); end
            checks++; if (par_bs_out !== exp_par_out() || from_bist !== exp_from_bist()) begin errors++; $display("FAIL b2b_update op=%0d: got %h/%h expected %h/%h", op, par_bs_out, from_bist, exp_par_out(), exp_from_bist()); end
        end
    endtask

    initial begin
        TRST_N = 1'b1;
        TMS = 1'b1;
        TDI = 1'b0;
        par_bs_in = '0;
        to_bist = '0;
        m_ir = 2;
        m_bs_upd = '0;
        m_bist_upd = '0;
        @(negedge TCK);
        #1;
        test_reset();
        test_idcode();
        test_ir_bypass();
        test_undefined_opcodes();
        test_sample_extest();
        test_highz_clamp();
        test_runbist();
        test_five_tms();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
